// File: rtl/z80_wait_gen_if.sv
// Z80 bus strobe bundle between the CPU core and the wait-state generator.
// The CPU side drives the strobes and slot number and receives WAIT back.
interface z80_wait_gen_if #(
  parameter int NUM_SLOTS = 4
) ();

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic              m1;
  logic              mreq;
  logic              iorq;
  logic              rd;
  logic              wr;
  logic              rfsh;
  logic [SLOT_W-1:0] slot;
  logic              wait_n;

  modport master (
    output m1, mreq, iorq, rd, wr, rfsh, slot,
    input  wait_n
  );

  modport slave (
    input  m1, mreq, iorq, rd, wr, rfsh, slot,
    output wait_n
  );

endinterface

// File: rtl/z80_wait_gen.sv
// Z80 WAIT generator: inserts a programmable number of wait states per
// bus cycle type, adds per-slot memory waits, honours a device hold
// request and keeps a saturating count of waited CPU clock periods.
module z80_wait_gen #(
  parameter int M1_WAITS   = 1,
  parameter int MEM_WAITS  = 0,
  parameter int IO_WAITS   = 1,
  parameter int IACK_WAITS = 2,
  parameter int CNT_W      = 4,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ce,
  input  logic                              enable,
  z80_wait_gen_if.slave                     bus,
  input  logic [NUM_SLOTS-1:0][CNT_W-1:0]   slot_waits,
  input  logic                              ext_wait,
  output logic                              busy,
  input  logic                              stat_clr,
  output logic [15:0]                       wait_total
);

  // Largest wait count the counter can hold; longer requests clip to this.
  localparam logic [CNT_W:0]   MAX_N   = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W:0] clip_waits(input int v);
    logic [31:0] vv;
    vv = v;
    if (v <= 0)
      return '0;
    else if (vv > 32'((1 << CNT_W) - 1))
      return MAX_N;
    else
      return vv[CNT_W:0];
  endfunction

  localparam logic [CNT_W:0] M1_N   = clip_waits(M1_WAITS);
  localparam logic [CNT_W:0] MEM_N  = clip_waits(MEM_WAITS);
  localparam logic [CNT_W:0] IO_N   = clip_waits(IO_WAITS);
  localparam logic [CNT_W:0] IACK_N = clip_waits(IACK_WAITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wait_q;
  logic             prev_active;

  logic             cycle_active;
  logic             start;
  logic [CNT_W:0]   base;
  logic [CNT_W:0]   extra;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] n_waits;

  // Direction strobes are not needed to pick the wait count.
  logic unused_strobes;
  assign unused_strobes = bus.rd | bus.wr;

  // Refresh cycles look like memory requests but must never be waited.
  assign cycle_active = (bus.mreq | bus.iorq) & ~bus.rfsh;
  assign start        = ce & cycle_active & ~prev_active;
  assign bus.wait_n   = wait_q;

  // Wait count for the cycle being started: type base plus slot extra for memory, clipped.
  always_comb begin
    base  = MEM_N;
    extra = '0;
    if (bus.m1 && bus.mreq)
      base = M1_N;
    else if (bus.m1 && bus.iorq)
      base = IACK_N;
    else if (bus.mreq)
      base = MEM_N;
    else if (bus.iorq)
      base = IO_N;
    if (bus.mreq)
      extra = {1'b0, slot_waits[bus.slot]};
    sum = base + extra;
    if (sum > MAX_N)
      n_waits = MAX_N[CNT_W-1:0];
    else
      n_waits = sum[CNT_W-1:0];
  end

  // Wait FSM; prev_active resets high so a cycle already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wait_q      <= 1'b1;
      busy        <= 1'b0;
      prev_active <= 1'b1;
    end else begin
      if (ce)
        prev_active <= cycle_active;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        wait_q <= 1'b1;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (n_waits != '0) begin
                state  <= COUNT;
                cnt    <= n_waits;
                wait_q <= 1'b0;
                busy   <= 1'b1;
              end else if (ext_wait) begin
                state  <= HOLD;
                wait_q <= 1'b0;
                busy   <= 1'b1;
              end else begin
                state  <= DONE;
              end
            end
          end
          COUNT: begin
            if (!cycle_active) begin
              state  <= IDLE;
              cnt    <= '0;
              wait_q <= 1'b1;
              busy   <= 1'b0;
            end else if (ce) begin
              cnt <= cnt - CNT_ONE;
              if (cnt == CNT_ONE) begin
                if (ext_wait) begin
                  state <= HOLD;
                end else begin
                  state  <= DONE;
                  wait_q <= 1'b1;
                  busy   <= 1'b0;
                end
              end
            end
          end
          HOLD: begin
            if (!cycle_active) begin
              state  <= IDLE;
              cnt    <= '0;
              wait_q <= 1'b1;
              busy   <= 1'b0;
            end else if (ce && !ext_wait) begin
              state  <= DONE;
              wait_q <= 1'b1;
              busy   <= 1'b0;
            end
          end
          DONE: begin
            wait_q <= 1'b1;
            busy   <= 1'b0;
            if (ce && !cycle_active)
              state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            wait_q <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating count of CPU clock periods spent waiting; clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_total <= 16'h0000;
    else if (stat_clr)
      wait_total <= 16'h0000;
    else if (ce && !wait_q && (wait_total != 16'hFFFF))
      wait_total <= wait_total + 16'd1;
  end

endmodule

// File: tb/tb_z80_wait_gen.sv
// Directed bench for z80_wait_gen: a table of single bus cycles with
// hand-computed wait counts, plus sequences for reset, abort, enable,
// asynchronous reset and counter saturation.
module tb_z80_wait_gen;

  logic             clk;
  logic             reset_n;
  logic             ce;
  logic             enable;
  logic [3:0][3:0]  slot_waits;
  logic             ext_wait;
  logic             busy;
  logic             stat_clr;
  logic [15:0]      wait_total;

  int n_vec;
  int n_bad;
  int waits_seen;
  int busy_seen;

  z80_wait_gen_if #(.NUM_SLOTS(4)) bus ();

  z80_wait_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .enable     (enable),
    .bus        (bus),
    .slot_waits (slot_waits),
    .ext_wait   (ext_wait),
    .busy       (busy),
    .stat_clr   (stat_clr),
    .wait_total (wait_total)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       m1;
    logic       mreq;
    logic       iorq;
    logic       rd;
    logic       wr;
    logic       rfsh;
    logic [1:0] slot;
    logic [3:0] sw;
    int         ext_hold;
    int         exp_waits;
    int         exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_strobes(input logic m1, input logic mreq, input logic iorq,
                             input logic rd, input logic wr, input logic rfsh);
    bus.m1   = m1;
    bus.mreq = mreq;
    bus.iorq = iorq;
    bus.rd   = rd;
    bus.wr   = wr;
    bus.rfsh = rfsh;
  endtask

  // One CPU clock period: ce high for one clk, then low for one clk.
  task automatic ce_period(input logic ext);
    @(negedge clk);
    ce       = 1'b1;
    ext_wait = ext;
    if (bus.wait_n === 1'b0) waits_seen++;
    if (busy === 1'b1) busy_seen++;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [15:0] t0;
    slot_waits         = '0;
    slot_waits[v.slot] = v.sw;
    bus.slot           = v.slot;
    set_strobes(0, 0, 0, 0, 0, 0);
    ce_period(1'b0);
    ce_period(1'b0);
    t0         = wait_total;
    waits_seen = 0;
    busy_seen  = 0;
    set_strobes(v.m1, v.mreq, v.iorq, v.rd, v.wr, v.rfsh);
    for (int i = 0; i < 24; i++)
      ce_period(i < v.ext_hold);
    set_strobes(0, 0, 0, 0, 0, 0);
    ce_period(1'b0);
    ce_period(1'b0);
    check_output({v.name, " waits"}, waits_seen, v.exp_waits);
    check_output({v.name, " busy"}, busy_seen, v.exp_busy);
    check_output({v.name, " total"}, 32'(wait_total - t0), v.exp_waits);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    waits_seen = 0;
    busy_seen  = 0;

    //             name          m1 mreq iorq rd wr rfsh slot sw ext  waits busy
    vecs[0] = '{"m1_fetch",     1, 1,   0,   1, 0, 0,   0,   0, 0,   1,    1};
    vecs[1] = '{"mem_slot2",    0, 1,   0,   1, 0, 0,   2,   3, 0,   3,    3};
    vecs[2] = '{"m1_saturate",  1, 1,   0,   1, 0, 0,   1,  15, 0,  15,   15};
    vecs[3] = '{"io_ext_hold",  0, 0,   1,   1, 0, 0,   0,   0, 10, 10,   10};
    vecs[4] = '{"refresh",      0, 1,   0,   0, 0, 1,   0,   7, 0,   0,    0};
    vecs[5] = '{"mem_plain",    0, 1,   0,   0, 1, 0,   0,   0, 0,   0,    0};
    vecs[6] = '{"iack_slot3",   1, 0,   1,   0, 0, 0,   3,   5, 0,   2,    2};
    vecs[7] = '{"io_wr_slot2",  0, 0,   1,   0, 1, 0,   2,   3, 0,   1,    1};
    vecs[8] = '{"mem_ext_only", 0, 1,   0,   1, 0, 0,   0,   0, 3,   3,    3};
    vecs[9] = '{"m1_slot2",     1, 1,   0,   1, 0, 0,   2,   3, 0,   4,    4};

    // Reset with an opcode fetch already on the bus.
    reset_n    = 1'b0;
    ce         = 1'b0;
    enable     = 1'b1;
    ext_wait   = 1'b0;
    stat_clr   = 1'b0;
    slot_waits = '0;
    bus.slot   = 2'd0;
    set_strobes(1, 1, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check_output("reset wait_n", 32'(bus.wait_n), 1);
    check_output("reset busy", 32'(busy), 0);
    check_output("reset wait_total", 32'(wait_total), 0);
    reset_n = 1'b1;

    // The fetch in progress at reset release must not be waited.
    waits_seen = 0;
    for (int i = 0; i < 4; i++) ce_period(1'b0);
    check_output("no start after reset", waits_seen, 0);
    set_strobes(0, 0, 0, 0, 0, 0);
    ce_period(1'b0);

    for (int i = 0; i < 10; i++)
      apply_stimulus(vecs[i]);

    // Memory cycle with 5 waits aborted when cnt is 3, on a clk without ce.
    slot_waits    = '0;
    slot_waits[0] = 4'd5;
    bus.slot      = 2'd0;
    set_strobes(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) ce_period(1'b0);
    check_output("abort pre wait_n", 32'(bus.wait_n), 0);
    set_strobes(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("abort wait_n", 32'(bus.wait_n), 1);
    check_output("abort busy", 32'(busy), 0);
    waits_seen = 0;
    for (int i = 0; i < 6; i++) ce_period(1'b0);
    check_output("abort no waits", waits_seen, 0);

    // Enable dropped mid-count, raised again while the same cycle is still active.
    set_strobes(0, 1, 0, 1, 0, 0);
    ce_period(1'b0);
    ce_period(1'b0);
    enable = 1'b0;
    @(negedge clk);
    check_output("enable off wait_n", 32'(bus.wait_n), 1);
    check_output("enable off busy", 32'(busy), 0);
    enable     = 1'b1;
    waits_seen = 0;
    for (int i = 0; i < 8; i++) ce_period(1'b0);
    check_output("enable rise no waits", waits_seen, 0);
    set_strobes(0, 0, 0, 0, 0, 0);
    ce_period(1'b0);
    ce_period(1'b0);

    // Asynchronous reset in the middle of a count.
    set_strobes(0, 1, 0, 1, 0, 0);
    ce_period(1'b0);
    ce_period(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async reset wait_n", 32'(bus.wait_n), 1);
    check_output("async reset busy", 32'(busy), 0);
    check_output("async reset wait_total", 32'(wait_total), 0);
    set_strobes(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ce_period(1'b0);
    ce_period(1'b0);

    // Long held I/O cycle with ce every clk drives wait_total into saturation.
    slot_waits = '0;
    @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    set_strobes(0, 0, 1, 1, 0, 0);
    ext_wait = 1'b1;
    repeat (65600) @(negedge clk);
    check_output("wait_total saturated", 32'(wait_total), 32'hFFFF);
    stat_clr = 1'b1;
    @(negedge clk);
    check_output("stat_clr over increment", 32'(wait_total), 0);
    stat_clr = 1'b0;
    @(negedge clk);
    check_output("count after clear", 32'(wait_total), 1);
    ext_wait = 1'b0;
    set_strobes(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    ce = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/z80_wait_gen.md
Z80_WAIT_GEN -- requirements
Module: z80_wait_gen

Interface
REQ-001 SHALL have parameter M1_WAITS, default 1, wait states for opcode fetch (M1 & MREQ).
REQ-002 SHALL have parameter MEM_WAITS, default 0, wait states for non-M1 memory read/write.
REQ-003 SHALL have parameter IO_WAITS, default 1, wait states for I/O read/write.
REQ-004 SHALL have parameter IACK_WAITS, default 2, wait states for interrupt acknowledge (M1 & IORQ).
REQ-005 SHALL have parameter CNT_W, default 4, counter width; NUM_SLOTS, default 4, primary slot count.
REQ-006 SHALL have port clk  input  1  system clock.
REQ-007 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port ce  input  1  CPU clock-enable (ce_3m58_p domain); all counting advances only on ce.
REQ-009 SHALL have port enable  input  1  0 forces wait_n high and FSM to IDLE.
REQ-010 SHALL have ports m1, mreq, iorq, rd, wr, rfsh  input  1 each  active-high CPU strobes.
REQ-011 SHALL have port slot  input  $clog2(NUM_SLOTS)  active primary slot of current address.
REQ-012 SHALL have port slot_waits  input  NUM_SLOTS x CNT_W  extra wait states per slot, memory cycles only.
REQ-013 SHALL have port ext_wait  input  1  device hold request; extends wait while high.
REQ-014 SHALL have port wait_n  output  1  registered active-low WAIT to CPU.
REQ-015 SHALL have port busy  output  1  high while FSM in COUNT or HOLD.
REQ-016 SHALL have ports stat_clr  input  1, wait_total  output  16  saturating count of ce periods with wait_n low.

Function
REQ-017 SHALL define cycle_active = (mreq | iorq) & ~rfsh; start = rising edge of cycle_active sampled on ce.
REQ-018 SHALL select base: M1&MREQ->M1_WAITS; M1&IORQ->IACK_WAITS; MREQ only->MEM_WAITS; IORQ only->IO_WAITS.
REQ-019 SHALL add slot_waits[slot] for memory cycles (including M1 fetch), never for I/O or IACK.
REQ-020 SHALL compute N = base + extra in CNT_W+1 bits, saturated to 2^CNT_W-1.
REQ-021 SHALL implement states IDLE, COUNT, HOLD, DONE.
REQ-022 IDLE, ce & start: N>0 -> COUNT, cnt<=N, wait_n<=0; N==0 & ext_wait -> HOLD, wait_n<=0; else -> DONE.
REQ-023 COUNT, ce: cnt<=cnt-1; when cnt==1: ext_wait -> HOLD, else -> DONE with wait_n<=1.
REQ-024 Thus wait_n SHALL be low for exactly N ce periods when ext_wait stays low.
REQ-025 HOLD, ce & ~ext_wait: -> DONE, wait_n<=1; ext_wait high keeps HOLD indefinitely.
REQ-026 DONE SHALL hold wait_n=1 and return to IDLE on the first ce with cycle_active low.
REQ-027 Abort: cycle_active low in COUNT or HOLD SHALL force IDLE and wait_n<=1 on the next clk, independent of ce.
REQ-028 enable low SHALL take effect next clk: IDLE, wait_n=1, cnt=0; enable rise mid-cycle SHALL not insert waits until next start.
REQ-029 Refresh (rfsh high) SHALL never produce a start or waits.
REQ-030 wait_total SHALL increment on each ce with wait_n low, saturate at 16'hFFFF; stat_clr wins over increment.
REQ-031 Defaults SHALL reproduce legacy MSX behaviour: one wait on M1 fetch, none on plain memory.

Reset
REQ-032 reset_n low SHALL asynchronously set state IDLE, cnt=0, wait_n=1, busy=0, wait_total=0.
REQ-033 After reset_n release, first start SHALL be detected only after cycle_active seen low on at least one ce.

Verification
REQ-034 Defaults, M1 fetch, slot_waits=0 -> wait_n low exactly 1 ce period, wait_total=1.
REQ-035 MEM read slot 2, slot_waits[2]=3, ext_wait=0 -> wait_n low 3 ce periods, busy high same span.
REQ-036 CNT_W=4, M1 fetch, slot_waits=15 -> N saturates to 15, wait_n low 15 ce periods.
REQ-037 IO read, ext_wait held 10 ce periods from start -> wait_n low 10 ce periods, release on first ce with ext_wait=0.
REQ-038 IORQ drops during COUNT with cnt=3 -> wait_n=1 next clk, state IDLE, no further waits; rfsh cycle -> no waits.
REQ-039 reset_n asserted mid-COUNT -> wait_n=1 immediately (asynchronous), wait_total=0; stat_clr with wait_total=16'hFFFF -> 0.
